logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the ALU datapath. Replaces the
//  fixed 16-bit OR/NOR/XOR/XNOR gate modules with one opcode-selected unit.
//  Input and output use valid/ready handshakes. Results carry zero, all-ones and
//  parity flags for the ALU status logic.
// PARAMETERS
//  WIDTH    16  operand/result width in bits (>=2)
//  OPW      3   opcode width (fixed by package; do not override)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts beat this cycle
//  in_op      in   OPW    opcode (see package encoding)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  out_valid  out  1      result beat offered
//  out_ready  in   1      consumer accepts result
//  out_y      out  WIDTH  result
//  out_zero   out  1      out_y == 0
//  out_ones   out  1      out_y == all ones
//  out_par    out  1      XOR-reduce of out_y
//  out_pop    out  $clog2(WIDTH+1)  popcount of out_y (LOGIC_POPCNT_EN only)
// BEHAVIOUR
//  - Opcodes: 0 AND, 1 OR, 2 NOR, 3 XOR, 4 XNOR, 5 NAND, 6 NOT_A, 7 PASS_A.
//  - Two register stages. S1 captures op/a/b. S2 captures y and flags computed from S1.
//  - Latency: a beat accepted at edge N is presented at edge N+2 if unstalled.
//  - Throughput: one beat per cycle. Capacity: 2 beats in flight.
//  - Transfer occurs on any edge with valid & ready both high on that interface.
//  - s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv.
//  - in_ready may depend combinationally on out_ready (no skid buffer).
//  - out_valid stays high and out_y/flags stay stable until accepted; in_op/in_a/in_b
//    are ignored when no transfer occurs.
//  - Both stages full and out_ready low: in_ready=0 and nothing moves.
//  - Simultaneous accept at input and output with full pipe: both stages shift, no bubble.
//  - Reset (any time, mid-flight beats discarded):
//    - out_valid=0, out_y=0, out_zero=1, out_ones=0, out_par=0, out_pop=0.
//    - Internal valids cleared.
//    - in_ready=1 during and after reset.
//  - Flags are computed on the full WIDTH result, with no truncation or sign handling.
//  - in_b is ignored for NOT_A and PASS_A.
// CONFIGURATION
//  LOGIC_POPCNT_EN defined:
//    - out_pop port exists.
//    - Popcount is computed in S1->S2 and registered alongside out_y.
//  LOGIC_POPCNT_EN undefined:
//    - Port and logic are absent.
//    - All other timing is identical.
// STRUCTURE
//  - Package logic_unit_pkg holds:
//    - typedef enum logic [2:0] logic_op_t (values above).
//    - localparam OPW=3.
//  - Sub-module logic_op_core: combinational op decode (op,a,b -> y, zero, ones, par).
//    Parametrised by WIDTH, instantiated once between S1 and S2.
//  - Pipeline control and registers live in logic_unit_pipe.
// TESTING (WIDTH=16)
//  1. OR a=16'h00F0 b=16'h0F00, out_ready=1 -> two edges later y=16'h0FF0,
//     zero=0, ones=0, par=0; NOR same operands -> y=16'hF00F.
//  2. XOR a=16'hAAAA b=16'hAAAA -> y=16'h0000, zero=1; XNOR same -> y=16'hFFFF,
//     ones=1, par=0.
//  3. Back-to-back: 8 beats, one per cycle, out_ready=1 -> 8 results in order on
//     consecutive cycles, in_ready never drops.
//  4. Stall: out_ready=0 with 3 beats offered -> first 2 accepted, in_ready=0 on
//     3rd. out_y holds beat 1. Raise out_ready -> beats 1,2,3 in order.
//  5. Reset mid-flight: 2 beats in pipe, assert rst asynchronously -> out_valid
//     drops immediately; after release no stale result appears.
//  6. LOGIC_POPCNT_EN build: PASS_A a=16'h8001 -> y=16'h8001, pop=2, par=0;
//     NOT_A a=16'h0000 -> pop=16.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Optional build macro used by logic_unit_pipe: LOGIC_POPCNT_EN (adds out_pop).
package logic_unit_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOR    = 3'd2,
    OP_XOR    = 3'd3,
    OP_XNOR   = 3'd4,
    OP_NAND   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } logic_op_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational opcode decode for the logic unit: result plus zero / all-ones /
// parity flags, evaluated over the full WIDTH result.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic_op_t          op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               ones,
  output logic               par
);

  // Opcode select; b is deliberately unused by the unary ops.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_NOR:    y = ~(a | b);
      OP_XOR:    y = a ^ b;
      OP_XNOR:   y = ~(a ^ b);
      OP_NAND:   y = ~(a & b);
      OP_NOT_A:  y = ~a;
      OP_PASS_A: y = a;
      default:   y = '0;
    endcase
  end

  // Status flags for the ALU status logic.
  always_comb begin
    zero = (y == '0);
    ones = &y;
    par  = ^y;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 holds the operands, S2 holds the result and flags. Backpressure ripples
// combinationally from out_ready to in_ready (no skid buffer).
// Optional build macro: LOGIC_POPCNT_EN adds a registered popcount output out_pop.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic                   out_zero,
  output logic                   out_ones,
  output logic                   out_par
`ifdef LOGIC_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_pop
`endif
);

  logic             s1_valid;
  logic_op_t        s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
  logic             s2_ones;
  logic             s2_par;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             core_ones;
  logic             core_par;

  // Handshake: a stage may load when it is empty or its contents move on.
  always_comb begin
    s2_adv   = ~s2_valid | out_ready;
    s1_adv   = ~s1_valid | s2_adv;
    in_ready = s1_adv;
  end

  // Stage 1: capture operands; data regs only load on an actual transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= logic_op_t'(in_op);
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op   (s1_op),
    .a    (s1_a),
    .b    (s1_b),
    .y    (core_y),
    .zero (core_zero),
    .ones (core_ones),
    .par  (core_par)
  );

  // Stage 2: register result and flags; held stable while out_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_zero  <= 1'b1;
      s2_ones  <= 1'b0;
      s2_par   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y    <= core_y;
        s2_zero <= core_zero;
        s2_ones <= core_ones;
        s2_par  <= core_par;
      end
    end
  end

`ifdef LOGIC_POPCNT_EN
  localparam int POPW = $clog2(WIDTH + 1);

  logic [POPW-1:0] core_pop;
  logic [POPW-1:0] s2_pop;

  // Popcount of the stage-1 result, summed bit by bit.
  always_comb begin
    core_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      core_pop = core_pop + POPW'(core_y[i]);
    end
  end

  // Popcount register travels with the S2 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_pop <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_pop <= core_pop;
    end
  end

  assign out_pop = s2_pop;
`endif

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_zero  = s2_zero;
  assign out_ones  = s2_ones;
  assign out_par   = s2_par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=16): vector table, scoreboard,
// and hand sequences for latency, stall, back-to-back and reset corners.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  typedef struct {
    logic [15:0] y;
    logic        zero;
    logic        ones;
    logic        par;
    int          pop;
  } exp_t;

  typedef struct {
    logic_op_t   op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_zero;
  logic        out_ones;
  logic        out_par;
`ifdef LOGIC_POPCNT_EN
  logic [4:0]  out_pop;
`endif

  int   checks;
  int   errors;
  int   cyc;
  int   n_out;
  int   out_cyc[$];
  exp_t sb[$];
  exp_t drv_exp;

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .out_par   (out_par)
`ifdef LOGIC_POPCNT_EN
    ,
    .out_pop   (out_pop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic_op_t op, logic [15:0] a, logic [15:0] b,
                              logic [15:0] y, logic z, logic o, logic p, int pop);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e.y = y; v.e.zero = z; v.e.ones = o; v.e.par = p; v.e.pop = pop;
    return v;
  endfunction

  function automatic exp_t model(logic_op_t op, logic [15:0] a, logic [15:0] b);
    exp_t e;
    case (op)
      OP_AND:    e.y = a & b;
      OP_OR:     e.y = a | b;
      OP_NOR:    e.y = ~(a | b);
      OP_XOR:    e.y = a ^ b;
      OP_XNOR:   e.y = ~(a ^ b);
      OP_NAND:   e.y = ~(a & b);
      OP_NOT_A:  e.y = ~a;
      default:   e.y = a;
    endcase
    e.zero = (e.y == 16'h0000);
    e.ones = (e.y == 16'hFFFF);
    e.par  = ^e.y;
    e.pop  = $countones(e.y);
    return e;
  endfunction

  task automatic check(input string name, input logic ok, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %s required %s", name, act, req);
    end
  endtask

  task automatic check_out(input exp_t e);
    logic ok;
    int   pop_act;
    ok = (out_y === e.y) && (out_zero === e.zero) && (out_ones === e.ones) && (out_par === e.par);
    pop_act = e.pop;
`ifdef LOGIC_POPCNT_EN
    pop_act = int'(out_pop);
    ok = ok && (pop_act == e.pop);
`endif
    check("sb_result", ok,
          $sformatf("y=%h z=%b o=%b p=%b pop=%0d", out_y, out_zero, out_ones, out_par, pop_act),
          $sformatf("y=%h z=%b o=%b p=%b pop=%0d", e.y, e.zero, e.ones, e.par, e.pop));
  endtask

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_out", 1'b0, $sformatf("y=%h", out_y), "no output");
        end else begin
          e = sb.pop_front();
          check_out(e);
        end
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
    end
  end

  // Offer one beat (called #1 after a posedge); returns #1 after the accepting edge.
  task automatic send(input vec_t v, output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; drv_exp = v.e;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    in_valid = 1'b0;
    check("send_timeout", 1'b0, "no accept", "accept within 200 cycles");
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size() == 0, $sformatf("%0d pending", sb.size()), "0 pending");
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];
  vec_t v1, v2, v3;
  int   st, tot_st, n0;

  initial begin
    vecs[0]  = mk(OP_OR,     16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 8);
    vecs[1]  = mk(OP_NOR,    16'h00F0, 16'h0F00, 16'hF00F, 0, 0, 0, 8);
    vecs[2]  = mk(OP_XOR,    16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 0);
    vecs[3]  = mk(OP_XNOR,   16'hAAAA, 16'hAAAA, 16'hFFFF, 0, 1, 0, 16);
    vecs[4]  = mk(OP_AND,    16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 4);
    vecs[5]  = mk(OP_NAND,   16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0, 0);
    vecs[6]  = mk(OP_NOT_A,  16'h1234, 16'hFFFF, 16'hEDCB, 0, 0, 1, 11);
    vecs[7]  = mk(OP_PASS_A, 16'h8001, 16'h1234, 16'h8001, 0, 0, 0, 2);
    vecs[8]  = mk(OP_XOR,    16'h0001, 16'h0000, 16'h0001, 0, 0, 1, 1);
    vecs[9]  = mk(OP_AND,    16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1, 0, 16);
    vecs[10] = mk(OP_OR,     16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0);
    vecs[11] = mk(OP_NOT_A,  16'h0000, 16'h5A5A, 16'hFFFF, 0, 1, 0, 16);

    checks = 0; errors = 0; cyc = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    drv_exp = vecs[0].e;

    repeat (3) @(negedge clk);
    check("reset_state",
          (out_valid === 1'b0) && (in_ready === 1'b1) && (out_y === 16'h0000) &&
          (out_zero === 1'b1) && (out_ones === 1'b0) && (out_par === 1'b0),
          $sformatf("v=%b r=%b y=%h z=%b o=%b p=%b", out_valid, in_ready, out_y, out_zero, out_ones, out_par),
          "v=0 r=1 y=0000 z=1 o=0 p=0");
`ifdef LOGIC_POPCNT_EN
    check("reset_pop", out_pop === 5'd0, $sformatf("%0d", out_pop), "0");
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Latency: accepted at edge N, result registered after edge N+1.
    send(vecs[0], st);
    check("latency_n", out_valid === 1'b0, $sformatf("v=%b", out_valid), "v=0");
    @(posedge clk); #1;
    check("latency_n1", (out_valid === 1'b1) && (out_y === 16'h0FF0),
          $sformatf("v=%b y=%h", out_valid, out_y), "v=1 y=0ff0");
    drain();

    // Table vectors.
    for (int i = 0; i < 12; i++) send(vecs[i], st);
    drain();

    // Back-to-back random beats.
    tot_st = 0;
    for (int i = 0; i < 8; i++) begin
      v1.op = logic_op_t'($urandom_range(0, 7));
      v1.a  = 16'($urandom);
      v1.b  = 16'($urandom);
      v1.e  = model(v1.op, v1.a, v1.b);
      send(v1, st);
      tot_st += st;
    end
    check("b2b_in_ready", tot_st == 0, $sformatf("%0d stalls", tot_st), "0 stalls");
    drain();
    check("b2b_consecutive", (out_cyc.size() >= 8) &&
          (out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-8] == 7),
          $sformatf("span=%0d", out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-8]), "span=7");

    // Stall: two beats fill the pipe, third is refused until out_ready rises.
    out_ready = 1'b0;
    v1 = mk(OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 8);
    v2 = mk(OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 0, 8);
    v2.e = model(v2.op, v2.a, v2.b);
    v3 = mk(OP_NAND, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 16);
    send(v1, st);
    send(v2, st);
    check("stall_accept2", st == 0, $sformatf("%0d stalls", st), "0 stalls");
    in_valid = 1'b1; in_op = v3.op; in_a = v3.a; in_b = v3.b; drv_exp = v3.e;
    @(negedge clk);
    check("stall_in_ready", in_ready === 1'b0, $sformatf("%b", in_ready), "0");
    check("stall_hold0", (out_valid === 1'b1) && (out_y === 16'h0FF0),
          $sformatf("v=%b y=%h", out_valid, out_y), "v=1 y=0ff0");
    in_a = 16'hDEAD;
    repeat (3) @(negedge clk);
    check("stall_hold3", (out_valid === 1'b1) && (out_y === 16'h0FF0) && (in_ready === 1'b0),
          $sformatf("v=%b y=%h r=%b", out_valid, out_y, in_ready), "v=1 y=0ff0 r=0");
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(v3, st);
    drain();

    // Reset mid-flight: two beats in the pipe are discarded.
    out_ready = 1'b0;
    send(vecs[3], st);
    send(vecs[4], st);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", (out_valid === 1'b0) && (in_ready === 1'b1) && (out_y === 16'h0000) &&
          (out_zero === 1'b1) && (out_ones === 1'b0) && (out_par === 1'b0),
          $sformatf("v=%b r=%b y=%h z=%b o=%b p=%b", out_valid, in_ready, out_y, out_zero, out_ones, out_par),
          "v=0 r=1 y=0000 z=1 o=0 p=0");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(negedge clk);
    check("rst_no_stale", (n_out == n0) && (out_valid === 1'b0),
          $sformatf("outs=%0d v=%b", n_out - n0, out_valid), "outs=0 v=0");

    // Pipe still functional after reset.
    @(posedge clk); #1;
    send(vecs[7], st);
    send(vecs[11], st);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
